// File: rtl/modulo5_pkg.sv
// ----------------------------------------------------------------------------
// modulo5_pkg : state encoding and remainder lookup for modulo_5_detector
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package modulo5_pkg;

   localparam int REM_W = 3;

   // Remainder states are encoded by their own remainder value.
   typedef enum logic [2:0] {
      S_IDLE = 3'd5,
      S_R0   = 3'd0,
      S_R1   = 3'd1,
      S_R2   = 3'd2,
      S_R3   = 3'd3,
      S_R4   = 3'd4
   } state_t;

   // r_next = (2*r + b) mod 5 as a table.
   function automatic state_t mod5_next(input state_t s, input logic b);
      state_t n;
      case (s)
         S_R0:    n = b ? S_R1 : S_R0;
         S_R1:    n = b ? S_R3 : S_R2;
         S_R2:    n = b ? S_R0 : S_R4;
         S_R3:    n = b ? S_R2 : S_R1;
         S_R4:    n = b ? S_R4 : S_R3;
         default: n = S_IDLE;
      endcase
      return n;
   endfunction

   function automatic logic [REM_W-1:0] state_rem(input state_t s);
      logic [REM_W-1:0] r;
      case (s)
         S_R1:    r = 3'd1;
         S_R2:    r = 3'd2;
         S_R3:    r = 3'd3;
         S_R4:    r = 3'd4;
         default: r = 3'd0;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/modulo_5_detector.sv
// ----------------------------------------------------------------------------
// modulo_5_detector : MSB-first serial word divisibility-by-5 classifier
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module modulo_5_detector
   import modulo5_pkg::*;
#(
   parameter int WORD_BITS   = 8,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   serial_in,
   input  logic                   serial_valid,
   input  logic                   frame_start,
   output logic                   result_valid,
   output logic [REM_W-1:0]       remainder,
   output logic                   divisible,
   output logic                   frame_error,
   output logic [COUNT_WIDTH-1:0] divisible_count
);

   localparam int CNT_W = $clog2(WORD_BITS + 1);
   localparam logic [CNT_W-1:0]       LAST_CNT  = CNT_W'(WORD_BITS - 1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   result_valid_q, result_valid_d;
   logic [REM_W-1:0]       remainder_q, remainder_d;
   logic                   divisible_q, divisible_d;
   logic                   frame_error_q, frame_error_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   state_t                 rem_next;

   assign rem_next = mod5_next(state_q, serial_in);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      result_valid_d = 1'b0;
      remainder_d    = remainder_q;
      divisible_d    = divisible_q;
      frame_error_d  = 1'b0;
      count_d        = count_q;

      if (serial_valid) begin
         if (frame_start) begin
            // Any non-idle state means a word is partially received.
            frame_error_d = (state_q != S_IDLE);
            state_d       = serial_in ? S_R1 : S_R0;
            cnt_d         = CNT_W'(1);
         end else if (state_q != S_IDLE) begin
            if (cnt_q == LAST_CNT) begin
               result_valid_d = 1'b1;
               remainder_d    = state_rem(rem_next);
               divisible_d    = (rem_next == S_R0);
               state_d        = S_IDLE;
               cnt_d          = '0;
               if ((rem_next == S_R0) && (count_q != COUNT_MAX)) begin
                  count_d = count_q + 1'b1;
               end
            end else begin
               state_d = rem_next;
               cnt_d   = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         result_valid_q <= 1'b0;
         remainder_q    <= '0;
         divisible_q    <= 1'b0;
         frame_error_q  <= 1'b0;
         count_q        <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         result_valid_q <= result_valid_d;
         remainder_q    <= remainder_d;
         divisible_q    <= divisible_d;
         frame_error_q  <= frame_error_d;
         count_q        <= count_d;
      end
   end

   assign result_valid    = result_valid_q;
   assign remainder       = remainder_q;
   assign divisible       = divisible_q;
   assign frame_error     = frame_error_q;
   assign divisible_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_modulo_5_detector.sv
// ----------------------------------------------------------------------------
// tb_modulo_5_detector : randomized self-checking bench for modulo_5_detector
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_modulo_5_detector;

   localparam int WORD_BITS   = 8;
   localparam int COUNT_WIDTH = 8;
   localparam int CMAX        = 255;

   logic       clock = 1'b0;
   logic       reset;
   logic       serial_in;
   logic       serial_valid;
   logic       frame_start;
   logic       result_valid;
   logic [2:0] remainder;
   logic       divisible;
   logic       frame_error;
   logic [7:0] divisible_count;

   modulo_5_detector #(
      .WORD_BITS   (WORD_BITS),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .serial_in       (serial_in),
      .serial_valid    (serial_valid),
      .frame_start     (frame_start),
      .result_valid    (result_valid),
      .remainder       (remainder),
      .divisible       (divisible),
      .frame_error     (frame_error),
      .divisible_count (divisible_count)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int exp_count = 0;

   // Observations gathered while a word is sent.
   int   p_rv, p_fe;
   int   p_rem;
   logic p_div;
   logic rv_last, fe_first;

   function automatic int model_count(input int cnt, input int value);
      if ((value % 5) == 0 && cnt < CMAX) return cnt + 1;
      return cnt;
   endfunction

   task automatic step(input logic v, input logic b, input logic fs,
                       output logic rv, output logic fe);
      serial_valid = v;
      serial_in    = b;
      frame_start  = fs;
      @(posedge clock);
      #1;
      rv = result_valid;
      fe = frame_error;
      if (rv) begin
         p_rv++;
         p_rem = int'(remainder);
         p_div = divisible;
      end
      if (fe) p_fe++;
   endtask

   // Sends the first nsend bits (MSB first) of value, with `gaps` idle cycles
   // scattered between bits; idle cycles carry random serial_in/frame_start.
   task automatic send_bits(input int value, input int nsend, input int gaps);
      int   gap_at[WORD_BITS];
      logic rv, fe;
      logic [15:0] v16;
      v16 = 16'(value);
      for (int k = 0; k < WORD_BITS; k++) gap_at[k] = 0;
      for (int k = 0; k < gaps; k++) gap_at[$urandom_range(1, WORD_BITS - 1)]++;
      p_rv = 0; p_fe = 0; rv_last = 1'b0; fe_first = 1'b0;
      for (int j = 0; j < nsend; j++) begin
         for (int g = 0; g < gap_at[j]; g++)
            step(1'b0, 1'($urandom), 1'($urandom), rv, fe);
         step(1'b1, v16[WORD_BITS-1-j], (j == 0), rv, fe);
         if (j == 0) fe_first = fe;
         if (j == WORD_BITS - 1) rv_last = rv;
      end
      serial_valid = 1'b0;
      frame_start  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; serial_valid = 1'b0; serial_in = 1'b0; frame_start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (result_valid !== 1'b0 || frame_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses got rv=%b fe=%b exp 0 0", result_valid, frame_error);
      end
      checks++;
      if (remainder !== 3'd0 || divisible !== 1'b0 || divisible_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_values got rem=%0d div=%b cnt=%0d exp 0 0 0",
                  remainder, divisible, divisible_count);
      end
      reset = 1'b0;
      exp_count = 0;
      @(posedge clock); #1;
   endtask

   task automatic test_single_word();
      logic rv, fe;
      send_bits(8'h0F, WORD_BITS, 0);
      exp_count = model_count(exp_count, 8'h0F);
      checks++;
      if (p_rv != 1 || rv_last !== 1'b1) begin
         errors++;
         $display("FAIL single_pulse got pulses=%0d on_last=%b exp 1 1", p_rv, rv_last);
      end
      checks++;
      if (p_rem != 15 % 5 || p_div !== 1'b1) begin
         errors++;
         $display("FAIL single_value got rem=%0d div=%b exp %0d 1", p_rem, p_div, 15 % 5);
      end
      checks++;
      if (int'(divisible_count) != exp_count) begin
         errors++;
         $display("FAIL single_count got %0d exp %0d", divisible_count, exp_count);
      end
      step(1'b0, 1'b0, 1'b0, rv, fe);
      checks++;
      if (rv !== 1'b0 || remainder !== 3'd0 || divisible !== 1'b1) begin
         errors++;
         $display("FAIL single_hold got rv=%b rem=%0d div=%b exp 0 0 1", rv, remainder, divisible);
      end
   endtask

   task automatic test_back_to_back();
      int words[3] = '{8'hA3, 8'h07, 8'hFF};
      int total_fe = 0;
      foreach (words[i]) begin
         send_bits(words[i], WORD_BITS, 0);
         total_fe += p_fe;
         exp_count = model_count(exp_count, words[i]);
         checks++;
         if (p_rv != 1 || rv_last !== 1'b1 || p_rem != words[i] % 5 ||
             p_div !== ((words[i] % 5) == 0)) begin
            errors++;
            $display("FAIL b2b_word%0d got pulses=%0d last=%b rem=%0d div=%b exp 1 1 %0d %b",
                     i, p_rv, rv_last, p_rem, p_div, words[i] % 5, ((words[i] % 5) == 0));
         end
      end
      checks++;
      if (total_fe != 0 || int'(divisible_count) != exp_count) begin
         errors++;
         $display("FAIL b2b_status got fe=%0d cnt=%0d exp 0 %0d", total_fe, divisible_count, exp_count);
      end
   endtask

   task automatic test_valid_gaps();
      send_bits(8'h05, WORD_BITS, 3);
      exp_count = model_count(exp_count, 8'h05);
      checks++;
      if (p_rv != 1 || rv_last !== 1'b1 || p_rem != 0 || p_div !== 1'b1) begin
         errors++;
         $display("FAIL gaps_word got pulses=%0d last=%b rem=%0d div=%b exp 1 1 0 1",
                  p_rv, rv_last, p_rem, p_div);
      end
      checks++;
      if (p_fe != 0 || int'(divisible_count) != exp_count) begin
         errors++;
         $display("FAIL gaps_status got fe=%0d cnt=%0d exp 0 %0d", p_fe, divisible_count, exp_count);
      end
   endtask

   task automatic test_frame_abort();
      send_bits(8'hF0, 4, 0);
      checks++;
      if (p_rv != 0 || p_fe != 0) begin
         errors++;
         $display("FAIL abort_partial got pulses=%0d fe=%0d exp 0 0", p_rv, p_fe);
      end
      send_bits(8'h0A, WORD_BITS, 0);
      exp_count = model_count(exp_count, 8'h0A);
      checks++;
      if (fe_first !== 1'b1 || p_fe != 1) begin
         errors++;
         $display("FAIL abort_error got first=%b fe=%0d exp 1 1", fe_first, p_fe);
      end
      checks++;
      if (p_rv != 1 || p_rem != 10 % 5 || p_div !== 1'b1 || int'(divisible_count) != exp_count) begin
         errors++;
         $display("FAIL abort_word got pulses=%0d rem=%0d div=%b cnt=%0d exp 1 0 1 %0d",
                  p_rv, p_rem, p_div, divisible_count, exp_count);
      end
   endtask

   task automatic test_reset_midword();
      send_bits(8'hB7, 5, 0);
      checks++;
      if (p_rv != 0) begin
         errors++;
         $display("FAIL midreset_partial got pulses=%0d exp 0", p_rv);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (remainder !== 3'd0 || divisible !== 1'b0 || divisible_count !== 8'd0 ||
          result_valid !== 1'b0 || frame_error !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear got rem=%0d div=%b cnt=%0d rv=%b fe=%b exp 0 0 0 0 0",
                  remainder, divisible, divisible_count, result_valid, frame_error);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      exp_count = 0;
      send_bits(8'h01, WORD_BITS, 0);
      checks++;
      if (p_rv != 1 || p_rem != 1 || p_div !== 1'b0 || p_fe != 0 || divisible_count !== 8'd0) begin
         errors++;
         $display("FAIL midreset_next got pulses=%0d rem=%0d div=%b fe=%0d cnt=%0d exp 1 1 0 0 0",
                  p_rv, p_rem, p_div, p_fe, divisible_count);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         int w;
         w = int'($urandom_range(0, 255));
         send_bits(w, WORD_BITS, int'($urandom_range(0, 3)));
         exp_count = model_count(exp_count, w);
         checks++;
         if (p_rv != 1 || rv_last !== 1'b1 || p_rem != w % 5 || p_div !== ((w % 5) == 0) ||
             p_fe != 0 || int'(divisible_count) != exp_count) begin
            errors++;
            $display("FAIL random_w%0d val=%0d got pulses=%0d rem=%0d div=%b fe=%0d cnt=%0d exp 1 %0d %b 0 %0d",
                     n, w, p_rv, p_rem, p_div, p_fe, divisible_count, w % 5, ((w % 5) == 0), exp_count);
         end
      end
   endtask

   task automatic test_saturation();
      int   pulses = 0;
      logic rv, fe;
      for (int n = 0; n < 260; n++) begin
         send_bits(0, WORD_BITS, 0);
         pulses += p_rv;
         exp_count = model_count(exp_count, 0);
      end
      checks++;
      if (pulses != 260 || int'(divisible_count) != exp_count || exp_count != CMAX) begin
         errors++;
         $display("FAIL sat_count got pulses=%0d cnt=%0d exp 260 %0d", pulses, divisible_count, CMAX);
      end
      p_rv = 0; p_fe = 0;
      for (int n = 0; n < 12; n++) step(1'b1, 1'($urandom), 1'b0, rv, fe);
      serial_valid = 1'b0;
      checks++;
      if (p_rv != 0 || p_fe != 0 || int'(divisible_count) != CMAX) begin
         errors++;
         $display("FAIL idle_bits got pulses=%0d fe=%0d cnt=%0d exp 0 0 %0d",
                  p_rv, p_fe, divisible_count, CMAX);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_valid_gaps();
      test_frame_abort();
      test_reset_midword();
      test_random();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/modulo_5_detector.md
Name: modulo_5_detector

Overview:
Consumes the MSB-first serial bit stream from the 8-bit parallel-in shift register and decides, per word, whether the unsigned word value is divisible by 5. The remainder is tracked incrementally with a 5-state FSM, so each word is classified the moment its last bit arrives. The block also flags words aborted by an early frame start and keeps a saturating count of divisible words for status readout.

Parameters:
WORD_BITS, 8, bits per word; legal range 2..16.
COUNT_WIDTH, 8, width of the divisible-word counter.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
serial_in  input  1  data bit, MSB of each word first
serial_valid  input  1  serial_in is valid this cycle; all state holds when 0
frame_start  input  1  qualified by serial_valid; this bit is the MSB of a new word
result_valid  output  1  one-cycle pulse: a complete word was classified
remainder  output  3  word value mod 5 (0..4), valid while result_valid=1
divisible  output  1  1 when remainder==0, valid while result_valid=1
frame_error  output  1  one-cycle pulse: in-progress word aborted by frame_start
divisible_count  output  COUNT_WIDTH  number of divisible words since reset, saturating

Behaviour:
- Reset, asynchronous: FSM to S_IDLE; bit counter=0; result_valid=0; remainder=0; divisible=0; frame_error=0; divisible_count=0. Reset mid-word discards the partial word. No result is produced.
- FSM states: S_IDLE (no word in progress) and S_R0..S_R4 (running remainder r).
- Remainder update per accepted bit: r_next = (2*r + bit) mod 5. Compute with a lookup on the 3-bit state, not with a divider.
- A bit is accepted only on an edge where serial_valid=1. When serial_valid=0, the FSM, counter and divisible_count hold, and the pulse outputs go to 0.
- Accepted bit with frame_start=1:
  - Start a new word with r = bit and counter = 1.
  - If a word was in progress (counter 1..WORD_BITS-1), assert frame_error for one cycle. The old word produces no result.
- Accepted bit with frame_start=0:
  - In S_IDLE, drop the bit. No output change.
  - Otherwise apply the remainder update and increment the counter.
- Word completion: on the edge that accepts bit number WORD_BITS:
  - Register result_valid=1, remainder=r_next, divisible=(r_next==0).
  - FSM returns to S_IDLE and the counter clears.
  - There is zero extra latency: the result is visible in the cycle immediately after the last bit's edge.
- result_valid, frame_error: single-cycle pulses, 0 on every other cycle. remainder and divisible hold their last values between pulses.
- Back-to-back: frame_start on the edge directly after completion starts the next word with no bubble. No frame_error, because the FSM is in S_IDLE.
- WORD_BITS=1 is not supported. frame_start alone never completes a word.
- divisible_count:
  - Increments on each completion with divisible=1.
  - Saturates at all-ones and does not wrap.
- frame_start together with serial_valid=0 is ignored.

Decomposition:
- Package modulo5_pkg:
  - state_t enum {S_IDLE, S_R0, S_R1, S_R2, S_R3, S_R4}.
  - Function mod5_next(state_t, logic bit) returning state_t.
  - Constant REM_W=3.
- No sub-module. The FSM, bit counter and saturating counter form one module, roughly 150 lines.

Test Plan:
1. Reset, then word 0x0F (15), MSB first, serial_valid held 1 -> one result_valid pulse after bit 8 with remainder=0, divisible=1, divisible_count=1.
2. Words 0xA3 (163), 0x07, 0xFF sent back-to-back -> three pulses on consecutive word boundaries:
   - 0xA3: remainder=3, divisible=0.
   - 0x07: remainder=2, divisible=0.
   - 0xFF: remainder=0, divisible=1.
   - No frame_error.
3. Word 0x05 with serial_valid deasserted for 3 random cycles between bits -> single result pulse only after the 8th valid bit, remainder=0.
4. frame_start after 4 bits of 0xF0, then full word 0x0A -> frame_error pulse on the restart edge, no result for the aborted word, then remainder=0 for 0x0A.
5. Reset asserted mid-word (after 5 bits), released, then word 0x01 -> no result from the partial word; outputs cleared immediately on reset; next result remainder=1.
6. 260 divisible words (0x00 repeated) -> divisible_count saturates at 255 and does not wrap; bits sent while idle without frame_start produce no pulses.
